// File: rtl/match_sequencer.sv
// Pong match sequencer: score keeping, serve / game-over countdowns and the
// per-rally ball speed ramp around the ball engine. All outputs registered.
module match_sequencer #(
    parameter int POINT_PAUSE   = 8000,
    parameter int GAME_PAUSE    = 131071,
    parameter int HITS_PER_STEP = 4,
    parameter int WIN_SCORE     = 9
) (
    input  logic       game_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] difficulty,
    input  logic       out_left,
    input  logic       out_right,
    input  logic       paddle_hit,
    output logic [3:0] speed,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [16:0] POINT_LOAD = 17'(POINT_PAUSE);
    localparam logic [16:0] GAME_LOAD  = 17'(GAME_PAUSE);
    localparam logic [3:0]  HITS_C     = 4'(HITS_PER_STEP);
    localparam logic [3:0]  WIN_C      = 4'(WIN_SCORE);

    state_e      state_q, state_d;
    logic [16:0] timer_q, timer_d;
    logic [3:0]  hit_q, hit_d;
    logic [3:0]  ramp_q, ramp_d;
    logic [3:0]  score_p1_q, score_p1_d;
    logic [3:0]  score_p2_q, score_p2_d;
    logic [3:0]  speed_q, speed_d;
    logic        ball_reset_q, ball_reset_d;
    logic        serve_dir_q, serve_dir_d;
    logic [1:0]  winner_q, winner_d;

    logic [3:0]  base_speed;
    logic [3:0]  hit_inc;
    logic        timer_done;
    logic [16:0] timer_next;
    logic        ramp_room;
    logic        out_evt;
    logic [3:0]  new_score;
    logic [4:0]  rally_sum;

    // Difficulty 0 still has to move the ball once the rally is live.
    assign base_speed = (difficulty == 4'd0) ? 4'd1 : difficulty;
    assign hit_inc    = hit_q + 4'd1;
    assign timer_done = (timer_q <= 17'd1);
    assign timer_next = start ? 17'd1 : (timer_q - 17'd1);
    assign ramp_room  = (({1'b0, base_speed} + {1'b0, ramp_q}) < 5'd15);
    // ball_reset_q marks the PLAY entry cycle, in which out events are ignored.
    assign out_evt    = !ball_reset_q && (out_left || out_right);

    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= 17'd0;
            hit_q        <= 4'd0;
            ramp_q       <= 4'd0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            speed_q      <= 4'd0;
            ball_reset_q <= 1'b0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            hit_q        <= hit_d;
            ramp_q       <= ramp_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            speed_q      <= speed_d;
            ball_reset_q <= ball_reset_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        hit_d        = hit_q;
        ramp_d       = ramp_q;
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        speed_d      = 4'd0;
        ball_reset_d = 1'b0;
        serve_dir_d  = serve_dir_q;
        winner_d     = winner_q;
        new_score    = 4'd0;
        rally_sum    = 5'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    winner_d   = 2'd0;
                    timer_d    = POINT_LOAD;
                    state_d    = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (timer_done) begin
                    state_d      = ST_PLAY;
                    ball_reset_d = 1'b1;
                end else begin
                    timer_d = timer_next;
                end
            end

            ST_PLAY: begin
                if (out_evt) begin
                    hit_d  = 4'd0;
                    ramp_d = 4'd0;
                    if (out_left) begin
                        new_score   = score_p1_q + 4'd1;
                        score_p1_d  = new_score;
                        serve_dir_d = 1'b0;
                    end else begin
                        new_score   = score_p2_q + 4'd1;
                        score_p2_d  = new_score;
                        serve_dir_d = 1'b1;
                    end
                    if (new_score == WIN_C) begin
                        winner_d = out_left ? 2'd1 : 2'd2;
                        timer_d  = GAME_LOAD;
                        state_d  = ST_OVER;
                    end else begin
                        timer_d = POINT_LOAD;
                        state_d = ST_SERVE;
                    end
                end else begin
                    if (paddle_hit) begin
                        if (hit_inc == HITS_C) begin
                            hit_d = 4'd0;
                            if (ramp_room) begin
                                ramp_d = ramp_q + 4'd1;
                            end
                        end else begin
                            hit_d = hit_inc;
                        end
                    end
                    // Speed follows the ramp including a step taken this cycle.
                    rally_sum = {1'b0, base_speed} + {1'b0, ramp_d};
                    speed_d   = (rally_sum > 5'd15) ? 4'd15 : rally_sum[3:0];
                end
            end

            ST_OVER: begin
                if (timer_done) begin
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    winner_d   = 2'd0;
                    timer_d    = POINT_LOAD;
                    state_d    = ST_SERVE;
                end else begin
                    timer_d = timer_next;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign speed      = speed_q;
    assign ball_reset = ball_reset_q;
    assign serve_dir  = serve_dir_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign winner     = winner_q;
    assign state      = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed scoreboard bench for match_sequencer: the driver pushes hand-computed
// output snapshots, a negedge monitor pops and compares them.
module tb_match_sequencer;

    localparam int W = 18;
    localparam logic [W-1:0] FULL = '1;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] difficulty;
    logic       out_left;
    logic       out_right;
    logic       paddle_hit;
    logic [3:0] speed;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic [1:0] state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        name_q[$];
    int           checks;
    int           failures;
    logic         prev_br;
    logic [3:0]   ramp_exp [8];
    logic [3:0]   sat_exp  [6];

    match_sequencer #(
        .POINT_PAUSE  (4),
        .GAME_PAUSE   (6),
        .HITS_PER_STEP(2),
        .WIN_SCORE    (3)
    ) dut (
        .game_clk  (clk),
        .reset_n   (reset_n),
        .start     (start),
        .difficulty(difficulty),
        .out_left  (out_left),
        .out_right (out_right),
        .paddle_hit(paddle_hit),
        .speed     (speed),
        .ball_reset(ball_reset),
        .serve_dir (serve_dir),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .winner    (winner),
        .state     (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] snap(input logic [1:0] st, input logic [3:0] sp,
                                          input logic br, input logic sd,
                                          input logic [3:0] p1, input logic [3:0] p2,
                                          input logic [1:0] w);
        return {st, sp, br, sd, p1, p2, w};
    endfunction

    task automatic push_exp(input logic [W-1:0] e, input logic [W-1:0] m, input string nm);
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(nm);
    endtask

    // One clock: inputs already set; expectation describes outputs after this edge.
    task automatic tick(input logic [W-1:0] e, input string nm);
        @(posedge clk);
        #1;
        push_exp(e, FULL, nm);
        @(negedge clk);
    endtask

    task automatic fast_serve(input logic [3:0] p1, input logic [3:0] p2,
                              input logic sd, input logic [3:0] spd);
        start = 1'b1;
        tick(snap(1, 0, 0, sd, p1, p2, 0), "start_cut");
        start = 1'b0;
        tick(snap(2, 0, 1, sd, p1, p2, 0), "play_entry");
        tick(snap(2, spd, 0, sd, p1, p2, 0), "rally_speed");
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] m;
        logic [W-1:0] got;
        string        nm;
        prev_br = 1'b0;
        forever begin
            @(negedge clk);
            got = {state, speed, ball_reset, serve_dir, score_p1, score_p2, winner};
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                m  = mask_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (((got ^ e) & m) != '0) begin
                    failures++;
                    $display("FAIL %s got st=%0d spd=%0d br=%0d dir=%0d p1=%0d p2=%0d win=%0d expected st=%0d spd=%0d br=%0d dir=%0d p1=%0d p2=%0d win=%0d",
                             nm, got[17:16], got[15:12], got[11], got[10], got[9:6], got[5:2], got[1:0],
                             e[17:16], e[15:12], e[11], e[10], e[9:6], e[5:2], e[1:0]);
                end
            end
            if (ball_reset) begin
                checks++;
                if (prev_br) begin
                    failures++;
                    $display("FAIL ball_reset_double got=1 expected=0 in consecutive cycle");
                end
            end
            prev_br = ball_reset;
        end
    end

    // Driver
    initial begin
        checks     = 0;
        failures   = 0;
        ramp_exp   = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd7};
        sat_exp    = '{4'd14, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        reset_n    = 1'b0;
        start      = 1'b0;
        difficulty = 4'd0;
        out_left   = 1'b0;
        out_right  = 1'b0;
        paddle_hit = 1'b0;

        @(negedge clk);
        tick(snap(0, 0, 0, 0, 0, 0, 0), "reset_hold");
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) tick(snap(0, 0, 0, 0, 0, 0, 0), "idle");

        // Game 1: normal serve countdown
        difficulty = 4'd5;
        start = 1'b1;
        tick(snap(1, 0, 0, 0, 0, 0, 0), "serve_entry");
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick(snap(1, 0, 0, 0, 0, 0, 0), "serve_count");
        tick(snap(2, 0, 1, 0, 0, 0, 0), "play_entry");
        tick(snap(2, 5, 0, 0, 0, 0, 0), "rally_speed");

        for (int i = 0; i < 8; i++) begin
            paddle_hit = (i % 2 == 0);
            tick(snap(2, ramp_exp[i], 0, 0, 0, 0, 0), "ramp");
        end
        paddle_hit = 1'b0;

        out_left = 1'b1;
        tick(snap(1, 0, 0, 0, 1, 0, 0), "out_left");
        tick(snap(1, 0, 0, 0, 1, 0, 0), "out_left_held");
        tick(snap(1, 0, 0, 0, 1, 0, 0), "out_left_held");
        out_left = 1'b0;
        tick(snap(1, 0, 0, 0, 1, 0, 0), "serve_count");
        tick(snap(2, 0, 1, 0, 1, 0, 0), "play_entry");
        tick(snap(2, 5, 0, 0, 1, 0, 0), "ramp_cleared");

        out_left  = 1'b1;
        out_right = 1'b1;
        tick(snap(1, 0, 0, 0, 2, 0, 0), "both_out");
        out_left  = 1'b0;
        out_right = 1'b0;

        start = 1'b1;
        tick(snap(1, 0, 0, 0, 2, 0, 0), "start_cut");
        start = 1'b0;
        tick(snap(2, 0, 1, 0, 2, 0, 0), "cut_play_entry");
        out_right = 1'b1;
        tick(snap(2, 5, 0, 0, 2, 0, 0), "entry_out_ignored");
        tick(snap(1, 0, 0, 1, 2, 1, 0), "out_right");
        out_right = 1'b0;

        fast_serve(4'd2, 4'd1, 1'b1, 4'd5);
        out_right = 1'b1;
        tick(snap(1, 0, 0, 1, 2, 2, 0), "out_right");
        out_right = 1'b0;
        fast_serve(4'd2, 4'd2, 1'b1, 4'd5);
        out_right = 1'b1;
        tick(snap(3, 0, 0, 1, 2, 3, 2), "p2_wins");
        out_right = 1'b0;

        for (int i = 0; i < 5; i++) tick(snap(3, 0, 0, 1, 2, 3, 2), "over_hold");
        tick(snap(1, 0, 0, 1, 0, 0, 0), "over_to_serve");

        // Game 2: minimum speed, saturation, ramp reset
        difficulty = 4'd0;
        fast_serve(4'd0, 4'd0, 1'b1, 4'd1);
        difficulty = 4'd14;
        tick(snap(2, 14, 0, 1, 0, 0, 0), "diff14");
        paddle_hit = 1'b1;
        for (int i = 0; i < 6; i++) tick(snap(2, sat_exp[i], 0, 1, 0, 0, 0), "saturate");
        out_left = 1'b1;
        tick(snap(1, 0, 0, 0, 1, 0, 0), "out_with_hit");
        out_left   = 1'b0;
        paddle_hit = 1'b0;
        difficulty = 4'd5;
        fast_serve(4'd1, 4'd0, 1'b0, 4'd5);
        out_left = 1'b1;
        tick(snap(1, 0, 0, 0, 2, 0, 0), "out_left");
        out_left = 1'b0;
        fast_serve(4'd2, 4'd0, 1'b0, 4'd5);

        // Asynchronous reset mid-rally, checked before any further clock edge
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        push_exp(snap(0, 0, 0, 0, 0, 0, 0), FULL, "async_reset");
        @(negedge clk);
        tick(snap(0, 0, 0, 0, 0, 0, 0), "reset_hold2");
        reset_n = 1'b1;

        // Game 3: player 1 wins, start cuts the game-over pause short
        start = 1'b1;
        tick(snap(1, 0, 0, 0, 0, 0, 0), "restart");
        fast_serve(4'd0, 4'd0, 1'b0, 4'd5);
        out_left = 1'b1;
        tick(snap(1, 0, 0, 0, 1, 0, 0), "out_left");
        out_left = 1'b0;
        fast_serve(4'd1, 4'd0, 1'b0, 4'd5);
        out_left = 1'b1;
        tick(snap(1, 0, 0, 0, 2, 0, 0), "out_left");
        out_left = 1'b0;
        fast_serve(4'd2, 4'd0, 1'b0, 4'd5);
        out_left = 1'b1;
        tick(snap(3, 0, 0, 0, 3, 0, 1), "p1_wins");
        out_left = 1'b0;
        start = 1'b1;
        tick(snap(3, 0, 0, 0, 3, 0, 1), "over_cut");
        start = 1'b0;
        tick(snap(1, 0, 0, 0, 0, 0, 0), "over_cut_serve");
        tick(snap(1, 0, 0, 0, 0, 0, 0), "serve_count");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d pending expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
